// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and default sizing for the two-port memory
// arbiter (top mem_arbiter, sub-module rr_arbiter2).
package mem_arbiter_pkg;

  // Default sizing of the shared word memory
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 500;

  // Controller sequencing: pick a winner, run one memory cycle, acknowledge
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index of a requester: 0 = instruction fetch, 1 = load/store
  typedef logic port_idx_t;

  // One-hot form of a port index, used for the per-port ack
  function automatic logic [1:0] port_onehot(input port_idx_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin winner select. Purely combinational;
// the caller owns the "last served" register and updates it on a grant.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_idx_t  i_last,
  output logic [1:0] o_grant,
  output logic       o_valid
);

  // A lone requester always wins; on a tie the port not served last wins
  always_comb begin
    o_grant = 2'b00;
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last == 1'b1) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word memory between an instruction-fetch port (0)
// and a load/store port (1). One access at a time, round-robin on ties,
// two-cycle latency from request to a one-cycle ack.
// Optional feature: define MEM_ARBITER_BOUNDS_CHECK_EN to block accesses at
// addr >= DEPTH and report them on err; otherwise every access reaches memory
// and err is tied low.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req,
  input  logic [1:0]             wr,
  input  logic [1:0][ADDR_W-1:0] addr,
  input  logic [1:0][DATA_W-1:0] wdata,
  output logic [1:0]             ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_datain,
  output logic                   mem_re,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_dataout
);

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
  localparam bit LP_CHECK_EN = 1'b1;
`else
  localparam bit LP_CHECK_EN = 1'b0;
`endif

  state_t              r_state;
  state_t              w_state_next;
  port_idx_t           r_last;
  port_idx_t           r_port;
  port_idx_t           w_port;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          w_grant;
  logic                w_valid;
  logic                w_blocked;

  rr_arbiter2 u_rr_arbiter2 (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  assign w_port = (w_grant == 2'b10);

  // Latched address out of range; constant 0 when checking is compiled out
  assign w_blocked = LP_CHECK_EN && ({1'b0, r_addr} >= LP_DEPTH);

  // Memory address and write data come straight from the latched request
  assign mem_addr   = r_addr;
  assign mem_datain = r_wdata;
  assign rdata      = r_rdata;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: IDLE waits for a request, ACCESS and DONE last one cycle each
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_valid ? ACCESS : IDLE;
      ACCESS:  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs: strobes only in ACCESS for an allowed access, ack only in DONE
  always_comb begin
    mem_re = 1'b0;
    mem_we = 1'b0;
    ack    = 2'b00;
    case (r_state)
      ACCESS: begin
        mem_re = !w_blocked && !r_wr;
        mem_we = !w_blocked &&  r_wr;
      end
      DONE:    ack = port_onehot(r_port);
      default: ack = 2'b00;
    endcase
  end

  // Capture the winner's request and remember it as last served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_last  <= w_port;
      r_port  <= w_port;
      r_wr    <= wr[w_port];
      r_addr  <= addr[w_port];
      r_wdata <= wdata[w_port];
    end
  end

  // Read data: memory word on an allowed read, zero on a blocked access,
  // otherwise held until the next read completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (r_state == ACCESS) begin
      if (w_blocked) begin
        r_rdata <= '0;
      end else if (!r_wr) begin
        r_rdata <= mem_dataout;
      end
    end
  end

`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
  logic r_err;

  // Error flag is set by a blocked access and lives only through DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_err <= w_blocked;
    end else if (r_state == DONE) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a transaction-level
// model (grant time, arbitration rule, reference memory) checked every cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int DEP = 500;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [1:0]          req = 2'b00;
  logic [1:0]          wr = 2'b00;
  logic [1:0][AW-1:0]  addr = '0;
  logic [1:0][DW-1:0]  wdata = '0;
  logic [1:0]          ack;
  logic [DW-1:0]       rdata;
  logic                err;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_datain;
  logic                mem_re;
  logic                mem_we;
  logic [DW-1:0]       mem_dataout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .wr          (wr),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_dataout (mem_dataout)
  );

  always #5 clk = ~clk;

  // Memory the DUT talks to: async read while re is high, write at clock edge
  logic [DW-1:0] mem [0:511];
  assign mem_dataout = mem_re ? mem[mem_addr[8:0]] : {DW{1'bz}};

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[8:0]] <= mem_datain;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] ref_mem [0:511];
  bit            ref_init = 1'b0;
  int            cyc = 0;
  int            free_at = 0;
  int            g_cyc = -100;
  logic          g_port = 1'b0;
  logic          g_wr = 1'b0;
  logic          g_oor = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  logic [DW-1:0] g_rval = '0;
  logic          m_last = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_datain = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk) begin
    logic w;
    if (!ref_init) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 16'h1000 + 16'(i);
      ref_init = 1'b1;
    end
    if (!reset_n) begin
      m_last = 1'b1; free_at = 0; g_cyc = -100;
      m_addr = '0; m_datain = '0; m_rdata = '0;
    end else begin
      // end of the memory cycle of the current grant
      if (cyc == g_cyc + 1) begin
        if (!g_oor && g_wr) ref_mem[g_addr[8:0]] = g_wdata;
        if (!g_wr || g_oor) m_rdata = g_oor ? '0 : g_rval;
      end
      // a new grant needs the previous access fully finished
      if (cyc >= free_at && req != 2'b00) begin
        w = (req == 2'b11) ? ~m_last : req[1];
        m_last  = w;
        g_cyc   = cyc;
        free_at = cyc + 3;
        g_port  = w;
        g_wr    = wr[w];
        g_addr  = addr[w];
        g_wdata = wdata[w];
`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
        g_oor   = (g_addr >= 16'(DEP));
`else
        g_oor   = 1'b0;
`endif
        g_rval  = ref_mem[g_addr[8:0]];
        m_addr  = g_addr;
        m_datain = g_wdata;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (reset_n) begin
      logic       e_re, e_we, e_err;
      logic [1:0] e_ack;
      e_re  = (cyc == g_cyc + 1) && !g_wr && !g_oor;
      e_we  = (cyc == g_cyc + 1) &&  g_wr && !g_oor;
      e_ack = (cyc == g_cyc + 2) ? (g_port ? 2'b10 : 2'b01) : 2'b00;
      e_err = (cyc == g_cyc + 2) && g_oor;
      check("cyc_ack", 32'(ack), 32'(e_ack));
      check("cyc_mem_re", 32'(mem_re), 32'(e_re));
      check("cyc_mem_we", 32'(mem_we), 32'(e_we));
      check("cyc_err", 32'(err), 32'(e_err));
      check("cyc_rdata", 32'(rdata), 32'(m_rdata));
      check("cyc_mem_addr", 32'(mem_addr), 32'(m_addr));
      check("cyc_mem_datain", 32'(mem_datain), 32'(m_datain));
      check("cyc_strobe_overlap", 32'(mem_re & mem_we), 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic single(input int p, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input int exp_strobes, input string nm,
                        output logic [15:0] rd, output logic e);
    int lat = -1;
    int strobes = 0;
    rd = '0;
    e  = 1'b0;
    @(negedge clk);
    req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (mem_re || mem_we) strobes++;
      if (ack[p]) begin
        lat = n; rd = rdata; e = err;
        break;
      end
    end
    req[p] = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'd2);
    check({nm, "_strobes"}, 32'(strobes), 32'(exp_strobes));
  endtask

  task automatic run_pair(input logic [15:0] a0, input logic [15:0] a1,
                          output int t0, output int t1,
                          output logic [15:0] r0, output logic [15:0] r1);
    t0 = -1; t1 = -1; r0 = '0; r1 = '0;
    @(negedge clk);
    req = 2'b11; wr = 2'b00; addr[0] = a0; addr[1] = a1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack[0] && t0 < 0) begin t0 = n; r0 = rdata; req[0] = 1'b0; end
      if (ack[1] && t1 < 0) begin t1 = n; r1 = rdata; req[1] = 1'b0; end
      if (t0 >= 0 && t1 >= 0) break;
    end
    req = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        e;
    int          t0, t1;
    logic [15:0] r0, r1;
    int          order [4];
    int          times [4];
    int          k;

    // reset state
    #12;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strobes", 32'({mem_re, mem_we}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_datain", 32'(mem_datain), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // port 0 writes then reads back
    single(0, 1'b1, 16'd10, 16'hBEEF, 1, "t1_write", rd, e);
    $display("t1 write addr 10 data 0xBEEF err=%0d", e);
    single(0, 1'b0, 16'd10, 16'h0000, 1, "t1_read", rd, e);
    $display("t1 read addr 10 rdata=0x%h err=%0d", rd, e);
    check("t1_rdata", 32'(rd), 32'h0000BEEF);
    check("t1_err", 32'(e), 32'd0);

    // simultaneous reads from reset: port 0 first, port 1 three cycles later
    do_reset();
    run_pair(16'd1, 16'd2, t0, t1, r0, r1);
    $display("t2 tie: port0 ack@%0d rdata=0x%h port1 ack@%0d rdata=0x%h", t0, r0, t1, r1);
    check("t2_p0_time", 32'(t0), 32'd2);
    check("t2_p1_time", 32'(t1), 32'd5);
    check("t2_p0_rdata", 32'(r0), 32'h00001001);
    check("t2_p1_rdata", 32'(r1), 32'h00001002);

    // sustained contention alternates ports
    do_reset();
    k = 0;
    for (int i = 0; i < 4; i++) begin order[i] = -1; times[i] = -1; end
    @(negedge clk);
    req = 2'b11; wr = 2'b00; addr[0] = 16'd3; addr[1] = 16'd4;
    for (int n = 1; n <= 30 && k < 4; n++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        order[k] = ack[1] ? 1 : 0;
        times[k] = n;
        $display("t3 ack %0d port %0d at cycle %0d rdata=0x%h", k, order[k], n, rdata);
        k++;
        if (k == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    check("t3_order0", 32'(order[0]), 32'd0);
    check("t3_order1", 32'(order[1]), 32'd1);
    check("t3_order2", 32'(order[2]), 32'd0);
    check("t3_order3", 32'(order[3]), 32'd1);
    check("t3_spacing", 32'(times[3] - times[0]), 32'd9);

    // accesses at address 500
    single(0, 1'b0, 16'd1, 16'h0000, 1, "t4_pre_read", rd, e);
    check("t4_pre_rdata", 32'(rd), 32'h00001001);
`ifdef MEM_ARBITER_BOUNDS_CHECK_EN
    single(1, 1'b1, 16'd500, 16'hDEAD, 0, "t4_oor_write", rd, e);
    $display("t4 write addr 500 err=%0d rdata=0x%h", e, rd);
    check("t4_wr_err", 32'(e), 32'd1);
    check("t4_wr_rdata", 32'(rd), 32'd0);
    single(0, 1'b0, 16'd500, 16'h0000, 0, "t4_oor_read", rd, e);
    $display("t4 read addr 500 err=%0d rdata=0x%h", e, rd);
    check("t4_rd_err", 32'(e), 32'd1);
    check("t4_rd_rdata", 32'(rd), 32'd0);
`else
    single(1, 1'b1, 16'd500, 16'hDEAD, 1, "t4_write500", rd, e);
    $display("t4 write addr 500 err=%0d", e);
    check("t4_wr_err", 32'(e), 32'd0);
    single(0, 1'b0, 16'd500, 16'h0000, 1, "t4_read500", rd, e);
    $display("t4 read addr 500 err=%0d rdata=0x%h", e, rd);
    check("t4_rd_err", 32'(e), 32'd0);
    check("t4_rd_rdata", 32'(rd), 32'h0000DEAD);
`endif
    check("t4_mem499", 32'(mem[499]), 32'h000011F3);

    // reset during the memory cycle of a port 1 write
    do_reset();
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'd20; wdata[1] = 16'h1234;
    @(negedge clk);
    check("t5_we_in_access", 32'(mem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    $display("t5 reset in ACCESS: ack=%b re=%b we=%b addr=0x%h rdata=0x%h err=%b",
             ack, mem_re, mem_we, mem_addr, rdata, err);
    check("t5_ack", 32'(ack), 32'd0);
    check("t5_strobes", 32'({mem_re, mem_we}), 32'd0);
    check("t5_mem_addr", 32'(mem_addr), 32'd0);
    check("t5_mem_datain", 32'(mem_datain), 32'd0);
    check("t5_rdata_err", 32'({rdata, err}), 32'd0);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_ack_in_reset", 32'(ack), 32'd0);
    end
    reset_n = 1'b1;
    run_pair(16'd6, 16'd7, t0, t1, r0, r1);
    $display("t5 tie after reset: port0 ack@%0d port1 ack@%0d", t0, t1);
    check("t5_tie_p0_time", 32'(t0), 32'd2);
    check("t5_tie_p1_time", 32'(t1), 32'd5);
    check("t5_tie_p0_rdata", 32'(r0), 32'h00001006);

    // request held through ack is served again
    t0 = -1; t1 = -1; r0 = '0; r1 = '0;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'd8;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack[0]) begin
        if (t0 < 0) begin t0 = n; r0 = rdata; end
        else begin t1 = n; r1 = rdata; req[0] = 1'b0; break; end
      end
    end
    req = 2'b00;
    $display("t6 held req: acks at %0d and %0d rdata=0x%h/0x%h", t0, t1, r0, r1);
    check("t6_first", 32'(t0), 32'd2);
    check("t6_gap", 32'(t1 - t0), 32'd3);
    check("t6_rdata", 32'(r1), 32'h00001008);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port controller sharing the single 16-bit word memory between two requesters (port 0: instruction fetch, port 1: load/store). It arbitrates round-robin, sequences the memory's `re`/`we` strobes one access at a time, and registers read data. It returns a one-cycle `ack` per request. This block is the only driver of the memory's `datain`, `addr`, `re` and `we` inputs.

## Interface
- `DATA_W`, 16, word width
- `ADDR_W`, 16, address width
- `DEPTH`, 500, number of implemented memory words; valid addresses are 0..DEPTH-1
- `clk` input 1: single clock, rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `req` input [1:0]: per-port request, held high until `ack`
- `wr` input [1:0]: per-port direction, 1 = write, 0 = read
- `addr` input [1:0][ADDR_W-1:0]: per-port address
- `wdata` input [1:0][DATA_W-1:0]: per-port write data
- `ack` output [1:0]: one-cycle completion pulse, per port
- `rdata` output DATA_W: registered read data, valid when `ack` is high for a read
- `err` output 1: out-of-range flag, valid with `ack`
- `mem_addr` output ADDR_W: memory address
- `mem_datain` output DATA_W: memory write data
- `mem_re` output 1: memory read enable
- `mem_we` output 1: memory write enable
- `mem_dataout` input DATA_W: memory read data; high-Z when `mem_re` is low

## Operation
- State machine states: IDLE, ACCESS, DONE.
- IDLE:
  - If any `req` bit is high, pick the winner and latch its `wr`/`addr`/`wdata` into internal registers. Go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS, in-range address:
  - Drive `mem_re` (read) or `mem_we` (write) high for exactly this one cycle.
  - `mem_addr` and `mem_datain` come from the latched registers.
  - On a read, capture `mem_dataout` into `rdata` at the end of the cycle.
  - Go to DONE.
- ACCESS, out-of-range address (`addr >= DEPTH`, with checking enabled):
  - Neither strobe is driven.
  - `rdata` is loaded with 0 and `err` is set.
  - Go to DONE.
- DONE:
  - `ack[winner]` is high for one cycle. `rdata` and `err` are valid during this cycle.
  - Go to IDLE.
  - `rdata` holds its value until the next read completes. `err` clears on leaving DONE.
- Round-robin arbitration:
  - A one-bit `last` register records the most recently served port.
  - If both ports request, the port ≠ `last` wins.
  - If one port requests, it wins regardless of `last`.
  - `last` updates on entry to ACCESS.
- Handshake rules:
  - A requester keeps `req` and its fields stable until `ack`.
  - `req` still high in the cycle after `ack` is a new request.
  - Changing fields before `ack` has no effect; they were latched in IDLE.
- `mem_re` and `mem_we` are never high together, and are never high outside ACCESS.

## Timing
- Request seen in IDLE at cycle 0 → ACCESS at cycle 1 → `ack` at cycle 2. Latency is 2 cycles.
- Throughput is one access per 3 cycles. Back-to-back requests alternate ports under contention.
- Reset values:
  - state IDLE, `last` = 1 (port 0 wins the first tie)
  - `ack` = 0, `rdata` = 0, `err` = 0
  - `mem_re` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_datain` = 0
- Reset mid-operation:
  - Immediate return to IDLE and all outputs forced to reset values. No `ack` is issued for the in-flight request.
  - If reset asserts during ACCESS, a write may or may not reach memory. The requester must reissue after reset.
- Both `req` bits rising in the same IDLE cycle is resolved by `last`; the loser is served next.

## Configuration
- Macro: `MEM_ARBITER_BOUNDS_CHECK_EN`.
- Defined: out-of-range addresses are blocked as described; `err` is functional.
- Undefined:
  - No range comparison; every access is passed to memory.
  - `err` is tied to 0.
  - Out-of-range reads return whatever the memory returns.

## Structure
- Package `mem_arbiter_pkg` holds:
  - the state enum (`IDLE`, `ACCESS`, `DONE`)
  - the `DATA_W`/`ADDR_W`/`DEPTH` default constants
  - the port-index typedef
- Sub-module `rr_arbiter2`:
  - combinational winner select from `req[1:0]` and `last`
  - outputs a one-hot grant and a `valid` flag

## Test plan
- Port 0 writes 0xBEEF to address 10, then reads address 10 → `mem_we` high one cycle; on the read, `ack[0]` at cycle 2 with `rdata` = 0xBEEF, `err` = 0.
- Both ports request reads from reset (port 0 addr 1, port 1 addr 2) → port 0 is acked first, port 1 is acked 3 cycles later, and both get the correct data.
- Both ports hold `req` for 4 accesses → ack order is 0, 1, 0, 1; strobes never overlap.
- With the macro defined, a read and a write to address 500 → `ack` with `err` = 1, `rdata` = 0x0000; `mem_re`/`mem_we` stay low and address 499 is unchanged.
- `reset_n` asserted during ACCESS of a port 1 write → all outputs go to 0 immediately, no `ack`; after release, the next tie goes to port 0.
- A `req` held through `ack` with the same fields → served again 3 cycles after the first `ack`.
